// File: rtl/barrel_shifter.sv
// Registered logical barrel shifter: log2 stages of left shifts,
// with bit reversal around the network to get right shifts.
module barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] stage [SHW+1];

  // Right shift = reverse, shift left, reverse back.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fwd[i] = dir ? in[i] : in[WIDTH-1-i];
    end
  end

  assign stage[0] = fwd;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    assign stage[k+1] = shamt[k] ? (stage[k] << (2**k)) : stage[k];
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = dir ? stage[SHW][i] : stage[SHW][WIDTH-1-i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= res;
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed self-checking bench for barrel_shifter.
// Each task drives its scenario and checks out inline.
module tb_barrel_shifter;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic [2:0] shamt;
  logic       dir;
  logic [7:0] out;

  int vectors;
  int errors;

  barrel_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .shamt (shamt),
    .dir   (dir),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(
    input logic [7:0] v,
    input logic [2:0] s,
    input logic       d
  );
    return d ? (v << s) : (v >> s);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in = 8'hFF; shamt = 3'd3; dir = 1'b1;
    #1;
    vectors++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: out=%h expected=%h", out, 8'h00);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: out=%h expected=%h", out, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'hF8) begin
      errors++;
      $display("FAIL reset_release: out=%h expected=%h", out, 8'hF8);
    end
  endtask

  task automatic test_left();
    @(negedge clk);
    in = 8'b01011101; shamt = 3'd2; dir = 1'b1;
    #1;
    vectors++;
    if (out !== 8'hF8) begin
      errors++;
      $display("FAIL left_latency: out=%h expected=%h", out, 8'hF8);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'h74) begin
      errors++;
      $display("FAIL left_shift2: out=%h expected=%h", out, 8'h74);
    end
  endtask

  task automatic test_right();
    @(negedge clk);
    in = 8'b01011101; shamt = 3'd2; dir = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'h17) begin
      errors++;
      $display("FAIL right_shift2: out=%h expected=%h", out, 8'h17);
    end
    @(negedge clk);
    in = 8'h80; shamt = 3'd7; dir = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'h01) begin
      errors++;
      $display("FAIL right_nosign: out=%h expected=%h", out, 8'h01);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] vin [4]  = '{8'hA5, 8'hA5, 8'h01, 8'hFE};
    logic [2:0] vsh [4]  = '{3'd0, 3'd0, 3'd7, 3'd7};
    logic       vdir [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] vexp [4] = '{8'hA5, 8'hA5, 8'h80, 8'h00};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in = vin[i]; shamt = vsh[i]; dir = vdir[i];
      @(posedge clk);
      #1;
      vectors++;
      if (out !== vexp[i]) begin
        errors++;
        $display("FAIL boundary_%0d: out=%h expected=%h", i, out, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back(input int rst_at);
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in = 8'b01011101;
      shamt = i[2:0];
      dir = i[3];
      exp = model(in, shamt, dir);
      @(posedge clk);
      #1;
      vectors++;
      if (out !== exp) begin
        errors++;
        $display("FAIL sweep_%0d: out=%h expected=%h", i, out, exp);
      end
      if (i == rst_at) begin
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (out !== 8'h00) begin
          errors++;
          $display("FAIL midrst_async: out=%h expected=%h", out, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (out !== exp) begin
          errors++;
          $display("FAIL midrst_resume: out=%h expected=%h", out, exp);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    test_reset();
    test_left();
    test_right();
    test_boundaries();
    test_back_to_back(-1);
    test_back_to_back(11);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
